// File: rtl/reg_list_sequencer.sv
// reg_list_sequencer: emits one register address and byte offset per beat for PUSH/POP/LDM/STM,
// followed by a single base-writeback beat; busy_o stalls decode until the sequence ends.
module reg_list_sequencer #(
    parameter int ADDR_WIDTH = 4,
    parameter int LIST_WIDTH = 9,
    parameter int OFF_WIDTH  = 8,
    parameter int SP_REG_NUM = 13,
    parameter int LR_REG_NUM = 14,
    parameter int PC_REG_NUM = 15
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  start_i,
    input  logic [1:0]            mode_i,
    input  logic [ADDR_WIDTH-1:0] base_reg_i,
    input  logic [LIST_WIDTH-1:0] reg_list_i,
    input  logic                  stall_i,
    output logic                  busy_o,
    output logic                  valid_o,
    output logic [ADDR_WIDTH-1:0] reg_addr_o,
    output logic                  is_load_o,
    output logic [ADDR_WIDTH-1:0] base_addr_o,
    output logic [OFF_WIDTH-1:0]  mem_offset_o,
    output logic                  last_o,
    output logic                  wb_en_o,
    output logic [OFF_WIDTH-1:0]  wb_offset_o
);
    localparam int KW = $clog2(LIST_WIDTH + 1);
    typedef enum logic [1:0] {IDLE, XFER, WB, DONE} state_t;
    state_t                r_state, w_state;
    logic [1:0]            r_mode, w_mode;
    logic [ADDR_WIDTH-1:0] r_base, w_base, w_low, w_addr;
    logic [LIST_WIDTH-1:0] r_list, w_list, w_eff;
    logic [KW-1:0]         r_k, w_k, r_n, w_n, w_pop;
    logic                  r_nowb, w_nowb, w_base_hit, w_cap, w_fire, w_single;
    logic [OFF_WIDTH-1:0]  w_4k, w_4n, w_mem_off, w_wb_off;
    logic                  r_busy, r_valid, r_is_load, r_last, r_wb_en;
    logic [ADDR_WIDTH-1:0] r_reg_addr, r_base_addr;
    logic [OFF_WIDTH-1:0]  r_mem_off, r_wb_off;
    // PUSH/POP keep the top bit (LR/PC); STM/LDM drop it
    always_comb begin
        w_eff = mode_i[1] ? reg_list_i : {1'b0, reg_list_i[LIST_WIDTH-2:0]};
        w_pop = '0;
        w_base_hit = 1'b0;
        for (int i = 0; i < LIST_WIDTH; i++) begin
            w_pop = w_pop + KW'(w_eff[i]);
            if (i < LIST_WIDTH - 1 && w_eff[i] && base_reg_i == ADDR_WIDTH'(i)) w_base_hit = 1'b1;
        end
    end
    always_comb begin
        w_fire  = r_valid && !stall_i;
        w_cap   = r_state == IDLE && start_i;
        w_mode  = w_cap ? mode_i : r_mode;
        w_base  = w_cap ? (mode_i[1] ? ADDR_WIDTH'(SP_REG_NUM) : base_reg_i) : r_base;
        w_n     = w_cap ? w_pop : r_n;
        w_nowb  = w_cap ? (mode_i == 2'b01 && w_base_hit) : r_nowb;
        w_list  = w_cap ? w_eff : (w_fire ? r_list & (r_list - LIST_WIDTH'(1)) : r_list);
        w_k     = w_cap ? '0 : (w_fire ? r_k + KW'(1) : r_k);
        w_state = r_state;
        case (r_state)
            IDLE:    w_state = start_i ? (w_eff == '0 ? DONE : XFER) : IDLE;
            XFER:    w_state = (w_fire && r_last) ? WB : XFER;
            WB:      w_state = stall_i ? WB : IDLE;
            default: w_state = IDLE;
        endcase
        w_low = '0;
        for (int i = LIST_WIDTH - 1; i >= 0; i--) if (w_list[i]) w_low = ADDR_WIDTH'(i);
        w_addr    = w_low == ADDR_WIDTH'(LIST_WIDTH - 1) ?
                    (w_mode[0] ? ADDR_WIDTH'(PC_REG_NUM) : ADDR_WIDTH'(LR_REG_NUM)) : w_low;
        w_single  = w_list != '0 && (w_list & (w_list - LIST_WIDTH'(1))) == '0;
        w_4k      = OFF_WIDTH'(w_k) << 2;
        w_4n      = OFF_WIDTH'(w_n) << 2;
        w_mem_off = w_4k - (w_mode == 2'b10 ? w_4n : '0);
        w_wb_off  = w_mode == 2'b10 ? -w_4n : w_4n;
    end
    // outputs are registered from next-state values so a stalled beat stays bit-stable
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state     <= IDLE;
            r_mode      <= '0;
            r_base      <= '0;
            r_list      <= '0;
            r_k         <= '0;
            r_n         <= '0;
            r_nowb      <= 1'b0;
            r_busy      <= 1'b0;
            r_valid     <= 1'b0;
            r_reg_addr  <= '0;
            r_is_load   <= 1'b0;
            r_base_addr <= '0;
            r_mem_off   <= '0;
            r_last      <= 1'b0;
            r_wb_en     <= 1'b0;
            r_wb_off    <= '0;
        end else begin
            r_state     <= w_state;
            r_mode      <= w_mode;
            r_base      <= w_base;
            r_list      <= w_list;
            r_k         <= w_k;
            r_n         <= w_n;
            r_nowb      <= w_nowb;
            r_busy      <= w_state != IDLE;
            r_valid     <= w_state == XFER;
            r_reg_addr  <= w_state == XFER ? w_addr : '0;
            r_is_load   <= w_state == XFER && w_mode[0];
            r_base_addr <= (w_state == XFER || w_state == WB) ? w_base : '0;
            r_mem_off   <= w_state == XFER ? w_mem_off : '0;
            r_last      <= w_state == XFER && w_single;
            r_wb_en     <= w_state == WB && !w_nowb;
            r_wb_off    <= w_state == WB ? w_wb_off : '0;
        end
    end
    assign busy_o       = r_busy;
    assign valid_o      = r_valid;
    assign reg_addr_o   = r_reg_addr;
    assign is_load_o    = r_is_load;
    assign base_addr_o  = r_base_addr;
    assign mem_offset_o = r_mem_off;
    assign last_o       = r_last;
    assign wb_en_o      = r_wb_en;
    assign wb_offset_o  = r_wb_off;
endmodule
